adc_acq_controller: RTL and testbench

- Sequences acquisitions from the dual-channel ADC1410 interface and writes them into a dual-port sample buffer.
- After the ADC reports init done, it arms on a start command and can wait for a level-crossing trigger on channel 1.
- It then captures a programmed number of decimated ch1/ch2 sample pairs and flags completion to the host logic.
- Sits between the ADC wrapper outputs (sample data, init done) and the sample buffer write port.

---
 rtl/adc_acq_controller.sv | 189 ++++++++++++++++++
 tb/tb_adc_acq_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_controller.sv
// ADC acquisition sequencer: arm, optional ch1 level trigger,
// decimated capture of {ch2, ch1} pairs into a sample buffer.
`timescale 1ns/1ps

module adc_acq_controller #(
    parameter int DATA_SIZE  = 16,
    parameter int ADDR_SIZE  = 10,
    parameter int DECIM_SIZE = 16
) (
    input  logic                   i_sys_clock,
    input  logic                   i_reset,
    input  logic                   i_init_done,
    input  logic [DATA_SIZE-1:0]   i_data_ch1,
    input  logic [DATA_SIZE-1:0]   i_data_ch2,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_trig_enable,
    input  logic [DATA_SIZE-1:0]   i_trig_level,
    input  logic [DECIM_SIZE-1:0]  i_decimation,
    input  logic [ADDR_SIZE-1:0]   i_num_samples,
    output logic                   o_wr_en,
    output logic [ADDR_SIZE-1:0]   o_wr_addr,
    output logic [2*DATA_SIZE-1:0] o_wr_data,
    output logic                   o_busy,
    output logic                   o_triggered,
    output logic                   o_done,
    output logic                   o_error
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_INIT,
        ARMED,
        CAPTURE
    } state_t;

    state_t state;

    // configuration captured on an accepted start
    logic                         trig_en_q;
    logic signed [DATA_SIZE-1:0]  level_q;
    logic [DECIM_SIZE-1:0]        decim_q;
    logic [ADDR_SIZE-1:0]         num_q;

    logic [DECIM_SIZE-1:0]        dec_cnt;
    logic [ADDR_SIZE-1:0]         index;
    logic [ADDR_SIZE-1:0]         last_index;
    logic signed [DATA_SIZE-1:0]  prev_ch1;
    logic                         prev_valid;

    logic strobe;
    logic crossing;
    logic take;
    logic last;

    // the decimation counter only runs while samples are being looked at
    assign strobe = ((state == ARMED && trig_en_q) || state == CAPTURE)
                    && (dec_cnt == '0);

    // first strobe in ARMED leaves prev_valid low, so it can only prime
    assign crossing = prev_valid
                      && (prev_ch1 < level_q)
                      && ($signed(i_data_ch1) >= level_q);

    // a sample is stored on a capture strobe, or on the triggering strobe
    assign take = strobe && !i_abort && i_init_done
                  && ((state == CAPTURE) || crossing);

    // count 0 wraps to all-ones, i.e. a full 2^ADDR_SIZE capture
    assign last_index = num_q - ADDR_SIZE'(1);
    assign last       = (index == last_index);

    // decimation counter: reload on strobe, otherwise count down
    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            dec_cnt <= '0;
        end else if ((state == ARMED && trig_en_q) || state == CAPTURE) begin
            if (dec_cnt == '0) begin
                dec_cnt <= decim_q;
            end else begin
                dec_cnt <= dec_cnt - DECIM_SIZE'(1);
            end
        end else begin
            dec_cnt <= '0;
        end
    end

    // sequencer state, buffer write port and sticky status flags
    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_busy      <= 1'b0;
            o_triggered <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            trig_en_q   <= 1'b0;
            level_q     <= '0;
            decim_q     <= '0;
            num_q       <= '0;
            index       <= '0;
            prev_ch1    <= '0;
            prev_valid  <= 1'b0;
        end else begin
            o_wr_en <= take;
            if (take) begin
                o_wr_addr <= index;
                o_wr_data <= {i_data_ch2, i_data_ch1};
                index     <= index + ADDR_SIZE'(1);
            end

            case (state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        trig_en_q   <= i_trig_enable;
                        level_q     <= $signed(i_trig_level);
                        decim_q     <= i_decimation;
                        num_q       <= i_num_samples;
                        o_done      <= 1'b0;
                        o_triggered <= 1'b0;
                        o_error     <= 1'b0;
                        o_busy      <= 1'b1;
                        state       <= WAIT_INIT;
                    end
                end

                WAIT_INIT: begin
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (i_init_done) begin
                        state      <= ARMED;
                        index      <= '0;
                        prev_valid <= 1'b0;
                    end
                end

                ARMED: begin
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (!i_init_done) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_error <= 1'b1;
                    end else if (!trig_en_q) begin
                        state       <= CAPTURE;
                        o_triggered <= 1'b1;
                    end else if (take) begin
                        o_triggered <= 1'b1;
                        if (last) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else if (strobe) begin
                        prev_ch1   <= $signed(i_data_ch1);
                        prev_valid <= 1'b1;
                    end
                end

                CAPTURE: begin
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (!i_init_done) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_error <= 1'b1;
                    end else if (take && last) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_acq_controller.sv
// Bench for adc_acq_controller: scoreboard of expected buffer
// writes, checked by a negedge monitor; status checked inline.
`timescale 1ns/1ps

module tb_adc_acq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [15:0] ch1;
    logic [15:0] ch2;
    logic        start;
    logic        abort;
    logic        trig_en;
    logic [15:0] level;
    logic [15:0] decim;
    logic [3:0]  num;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        triggered;
    logic        done;
    logic        error;

    adc_acq_controller #(
        .DATA_SIZE(16),
        .ADDR_SIZE(4),
        .DECIM_SIZE(16)
    ) dut (
        .i_sys_clock  (clk),
        .i_reset      (rst),
        .i_init_done  (init_done),
        .i_data_ch1   (ch1),
        .i_data_ch2   (ch2),
        .i_start      (start),
        .i_abort      (abort),
        .i_trig_enable(trig_en),
        .i_trig_level (level),
        .i_decimation (decim),
        .i_num_samples(num),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy),
        .o_triggered  (triggered),
        .o_done       (done),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int wr_count  = 0;
    int first_wr  = -1;
    int last_wr   = -1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pair(input logic [15:0] v);
        return {v ^ 16'h5A5A, v};
    endfunction

    task automatic drive(input logic [15:0] v);
        ch1 = v;
        ch2 = v ^ 16'h5A5A;
    endtask

    task automatic push(input int a, input int v, input logic l);
        exp_t e;
        e.last = l;
        e.addr = 4'(a);
        e.data = pair(16'(v));
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // n cycles of ramp data; cycle k carries value base+k
    task automatic run(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            drive(16'(base + k));
            step();
        end
    endtask

    task automatic start_cap(input logic t, input int lvl, input int d,
                             input int n);
        trig_en   = t;
        level     = 16'(lvl);
        decim     = 16'(d);
        num       = 4'(n);
        start     = 1'b1;
        start_cyc = cyc;
        wr_count  = 0;
        first_wr  = -1;
        last_wr   = -1;
    endtask

    task automatic sb_empty(input string tag);
        check(tag, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // write monitor: every buffer write must match the scoreboard head
    always @(negedge clk) begin
        if (wr_en) begin
            exp_t e;
            wr_count++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (sb.size() == 0) begin
                check("unexpected_wr", 64'(wr_addr), 64'hFFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("done_with_wr", 64'(done), 64'(e.last));
            end
        end
    end

    int seq_a[8] = '{0, 0, 50, 90, 110, 120, 120, 120};
    int seq_b[9] = '{0, 0, 110, 120, 80, 105, 130, 130, 130};

    initial begin
        rst       = 1'b1;
        init_done = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        trig_en   = 1'b0;
        level     = '0;
        decim     = '0;
        num       = '0;
        drive(16'd0);
        step();
        step();
        check("rst_outputs",
              64'({wr_en, wr_addr, wr_data, busy, triggered, done, error}),
              64'd0);
        rst = 1'b0;
        step();

        // waits in WAIT_INIT while init is low; abort leaves it
        start_cap(1'b0, 0, 0, 4);
        run(5, 0);
        check("wait_init_busy", 64'(busy), 64'd1);
        check("wait_init_nowr", 64'(wr_count), 64'd0);
        abort = 1'b1;
        step();
        check("wait_init_abort", 64'(busy), 64'd0);
        init_done = 1'b1;
        step();

        // trigger off, decimation 0, four consecutive samples
        start_cap(1'b0, 0, 0, 4);
        for (int i = 0; i < 4; i++) push(i, 1003 + i, i == 3);
        run(1, 1000);
        check("busy_after_start", 64'(busy), 64'd1);
        run(7, 1001);
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_sticky", 64'(done), 64'd1);
        check("trig_when_off", 64'(triggered), 64'd1);
        check("latency", 64'(first_wr - start_cyc), 64'd4);
        check("ramp_count", 64'(wr_count), 64'd4);
        sb_empty("sb_ramp");
        run(2, 0);

        // rising crossing of 100 at 110
        start_cap(1'b1, 100, 0, 2);
        push(0, 110, 1'b0);
        push(1, 120, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) check("trig_a_before", 64'(triggered), 64'd0);
            if (k == 5) check("trig_a_after", 64'(triggered), 64'd1);
            drive(16'(seq_a[k]));
            step();
        end
        check("trig_a_done", 64'(done), 64'd1);
        sb_empty("sb_trig_a");

        // starts above level: first strobe only primes
        start_cap(1'b1, 100, 0, 2);
        push(0, 105, 1'b0);
        push(1, 130, 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (k == 5) check("trig_b_before", 64'(triggered), 64'd0);
            if (k == 6) check("trig_b_after", 64'(triggered), 64'd1);
            drive(16'(seq_b[k]));
            step();
        end
        sb_empty("sb_trig_b");

        // decimation 3: strobes four cycles apart
        start_cap(1'b0, 0, 3, 2);
        push(0, 2003, 1'b0);
        push(1, 2007, 1'b1);
        run(12, 2000);
        check("decim_gap", 64'(last_wr - first_wr), 64'd4);
        check("decim_count", 64'(wr_count), 64'd2);
        sb_empty("sb_decim");

        // count 0 means the full 16-entry buffer
        start_cap(1'b0, 0, 0, 0);
        for (int i = 0; i < 16; i++) push(i, 3003 + i, i == 15);
        run(24, 3000);
        check("full_count", 64'(wr_count), 64'd16);
        check("full_done", 64'(done), 64'd1);
        sb_empty("sb_full");

        // abort after two of eight writes
        start_cap(1'b0, 0, 0, 8);
        push(0, 4003, 1'b0);
        push(1, 4004, 1'b0);
        run(5, 4000);
        abort = 1'b1;
        run(6, 4005);
        check("abort_count", 64'(wr_count), 64'd2);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_trig_kept", 64'(triggered), 64'd1);
        sb_empty("sb_abort");

        // start while busy, with changed config, is ignored
        start_cap(1'b0, 0, 0, 4);
        for (int i = 0; i < 4; i++) push(i, 5003 + i, i == 3);
        run(5, 5000);
        trig_en = 1'b1;
        level   = 16'd30000;
        decim   = 16'd3;
        num     = 4'd8;
        start   = 1'b1;
        run(8, 5005);
        check("busy_start_count", 64'(wr_count), 64'd4);
        check("busy_start_gap", 64'(last_wr - first_wr), 64'd3);
        check("busy_start_done", 64'(done), 64'd1);
        sb_empty("sb_busy_start");

        // init loss mid-capture
        start_cap(1'b0, 0, 0, 8);
        for (int i = 0; i < 3; i++) push(i, 6003 + i, 1'b0);
        run(6, 6000);
        init_done = 1'b0;
        run(5, 6006);
        check("init_loss_err", 64'(error), 64'd1);
        check("init_loss_busy", 64'(busy), 64'd0);
        check("init_loss_count", 64'(wr_count), 64'd3);
        sb_empty("sb_init_loss");
        init_done = 1'b1;
        start_cap(1'b0, 0, 0, 1);
        push(0, 7003, 1'b1);
        run(1, 7000);
        check("err_cleared", 64'(error), 64'd0);
        run(7, 7001);
        check("single_count", 64'(wr_count), 64'd1);
        sb_empty("sb_single");

        // start and abort together in IDLE: abort wins
        start_cap(1'b0, 0, 0, 2);
        abort = 1'b1;
        run(1, 0);
        check("start_abort_busy", 64'(busy), 64'd0);
        run(6, 1);
        check("start_abort_nowr", 64'(wr_count), 64'd0);

        // reset mid-capture
        start_cap(1'b0, 0, 0, 8);
        push(0, 8003, 1'b0);
        push(1, 8004, 1'b0);
        run(5, 8000);
        rst = 1'b1;
        run(1, 8005);
        check("rst_mid_outputs",
              64'({wr_en, busy, triggered, done, error}), 64'd0);
        rst = 1'b0;
        run(5, 8006);
        check("rst_mid_count", 64'(wr_count), 64'd2);
        sb_empty("sb_rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
